segment_remover_axis_dyn: RTL and testbench
===========================================

Name: segment_remover_axis_dyn

Overview:
- Full-datapath AXI-Stream segment remover, byte granular. Deletes a run-time-sized segment of `seg_size` bytes, starting at a fixed byte offset `REMOVE_OFFSET`, from every packet.
- Re-packs the remaining bytes into dense output beats and emits an extra flush beat when one is needed.
- Sits in the NMU ingress path after the packet FIFO. It is the successor to the lane-mux remover FSM: it owns the data, tkeep and handshake itself instead of only producing mux selects and write enables.

Parameters:
- AXIS_BUS_WIDTH, 64, tdata width in bits; multiple of 8; W = AXIS_BUS_WIDTH/8 bytes.
- MAX_REMOVE_BYTES, 8, largest legal `seg_size`; must be ≤ W.
- REMOVE_OFFSET, 12, byte index of the first removed byte; must be ≥1.
- MAX_PACKET_LENGTH, 1522, max bytes per packet; sizes the internal byte counter to clog2(MAX_PACKET_LENGTH+1) bits.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous reset, active-high.
- seg_size  in  clog2(MAX_REMOVE_BYTES+1)  bytes to remove; sampled on the first beat of each packet.
- s_axis_tdata  in  AXIS_BUS_WIDTH  input data; byte 0 = [7:0].
- s_axis_tkeep  in  W  input byte enables; contiguous from LSB; only the tlast beat may be partial.
- s_axis_tlast  in  1  end of input packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  AXIS_BUS_WIDTH  output data.
- m_axis_tkeep  out  W  output byte enables; contiguous from LSB.
- m_axis_tlast  out  1  end of output packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

Behaviour:
- Clocking and reset: one clock, `aclk`. Reset is asynchronous and active-high on `areset`; all flops clear immediately when it asserts.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, s_axis_tready=0 while in reset, state=IDLE, residue empty, byte counter=0.
- Segment size latch: `seg_size` is latched on the accepted first beat of a packet. Values above MAX_REMOVE_BYTES are clamped to MAX_REMOVE_BYTES. Changes to `seg_size` mid-packet are ignored.
- Byte keep rule: input byte at packet index i is kept iff i < REMOVE_OFFSET or i ≥ REMOVE_OFFSET+seg. Index i is the byte counter plus the byte's lane position.
- Compaction: kept bytes are appended after residue bytes (0..W-1 held), in order.
  - When the total reaches ≥ W, the low W bytes load the output register and the excess stays in the residue.
  - On tlast: if the total ≤ W, one beat is emitted with tlast=1 and tkeep = (1<<total)-1. Otherwise a full beat is emitted, the state goes to FLUSH, and the remainder is sent next as a tlast beat.
- Output register: single stage, so latency is 1 cycle from input acceptance to m_axis_tvalid. m_axis_* stay stable while tvalid=1 and tready=0.
- Input ready: s_axis_tready = (~m_axis_tvalid | m_axis_tready) & (state != FLUSH) & ~areset.
- State machine:
  - IDLE: awaiting the first beat. On accept: latch seg, go to BODY; if tlast, emit and stay in IDLE, or go to FLUSH if a flush beat is needed.
  - BODY: mid-packet. tlast goes to IDLE or FLUSH.
  - FLUSH: input stalled. When the output slot frees, the residue loads as a tlast beat and the state goes to IDLE. The counter and residue clear.
- Zero-output beats: an input beat whose bytes are all removed and which does not fill W produces no output beat; the input is still accepted.
- Packet shorter than REMOVE_OFFSET: passes through unchanged.
- Packet ending inside the segment: the output is truncated at REMOVE_OFFSET bytes. REMOVE_OFFSET ≥ 1 guarantees every output packet is non-empty.
- seg=0: output is identical to input, beat for beat.
- Back-to-back packets: the first beat of packet N+1 may be accepted in the cycle after packet N's final output beat is loaded. No bubble is required except for FLUSH.

Optional Feature:
- Macro: SEGMENT_REMOVER_STATS_EN.
- When defined:
  - Adds output ports stat_pkt_count [31:0] and stat_bytes_removed [31:0].
  - stat_pkt_count increments on every output tlast handshake.
  - stat_bytes_removed adds the number of bytes actually removed per packet (min(seg, max(0, len-REMOVE_OFFSET))) at that same handshake.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined: the ports and counters do not exist; no other behaviour changes.

Test Plan (W=8, REMOVE_OFFSET=12):
- 24-byte packet, bytes 0..23, seg=4, m_tready=1 -> out beats: 0..7 keep 0xFF; 8..11,16..19 keep 0xFF; 20..23 keep 0x0F tlast (FLUSH). s_tready is low for exactly 1 cycle.
- 10-byte packet (keep 0xFF, then 0x03), seg=4 -> output identical, 2 beats, last keep 0x03.
- 14-byte packet, seg=4 -> beat 0..7 keep 0xFF; beat 8..11 keep 0x0F tlast. Removed count is 2 with SEGMENT_REMOVER_STATS_EN.
- 24-byte packet, seg=4 latched; seg_size changed to 0 on beat 1; m_tready held low 5 cycles mid-packet -> output matches case 1. m_axis_* are stable while stalled, and s_tready=0 while the output is full.
- Two back-to-back 16-byte packets, seg=0 then seg=8 -> first packet unchanged (2 beats). Second packet: 0..7 keep 0xFF; then bytes 8..11 only, keep 0x0F tlast (bytes 12..15 removed).
- areset pulse while packet 1 is mid-transfer -> all outputs 0 immediately. A new 8-byte packet after reset passes unchanged with no stale residue.

Source files
------------

// File: rtl/segment_remover_axis_dyn_if.sv
// AXI-Stream bus bundle for the segment remover (data, byte keep, last, valid/ready).
interface segment_remover_axis_dyn_if #(
  parameter int DATA_W = 64
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/segment_remover_axis_dyn.sv
// Byte-granular AXI-Stream segment remover: drops seg bytes at REMOVE_OFFSET and re-packs the rest.
// Optional packet/removed-byte counters when SEGMENT_REMOVER_STATS_EN is defined.
module segment_remover_lane #(
  parameter int LANE   = 0,
  parameter int OFFSET = 12,
  parameter int CNT_W  = 11,
  parameter int SEG_W  = 4
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [SEG_W-1:0] seg_i,
  input  logic             vld_i,
  output logic             keep_o
);
  logic [31:0] idx;
  assign idx    = 32'(cnt_i) + 32'(LANE);
  assign keep_o = vld_i & ((idx < 32'(OFFSET)) | (idx >= 32'(OFFSET) + 32'(seg_i)));
endmodule

module segment_remover_axis_dyn #(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int MAX_REMOVE_BYTES  = 8,
  parameter int REMOVE_OFFSET     = 12,
  parameter int MAX_PACKET_LENGTH = 1522,
  localparam int W     = AXIS_BUS_WIDTH / 8,
  localparam int SEG_W = $clog2(MAX_REMOVE_BYTES + 1)
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [SEG_W-1:0]             seg_size,
  segment_remover_axis_dyn_if.slave    s_axis,
  segment_remover_axis_dyn_if.master   m_axis
`ifdef SEGMENT_REMOVER_STATS_EN
  ,
  output logic [31:0]                  stat_pkt_count,
  output logic [31:0]                  stat_bytes_removed
`endif
);
  localparam int CNT_W = $clog2(MAX_PACKET_LENGTH + 1);
  localparam int RC_W  = (W > 1) ? $clog2(W) : 1;
  localparam int PW    = $clog2(2 * W);

  typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [SEG_W-1:0]      seg_q, seg_d, seg_clamp, seg_eff;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [W-1:0][7:0]     res_q, res_d, dout_q, dout_d, din;
  logic [RC_W-1:0]       rc_q, rc_d;
  logic [W-1:0]          keep_q, keep_d, kept;
  logic                  last_q, last_d, valid_q, valid_d;
  logic [2*W-1:0][7:0]   comb;
  logic [PW-1:0]         total;
  logic                  slot_free, s_ready, accept;

  function automatic logic [W-1:0] mask_f(input logic [PW-1:0] n);
    for (int k = 0; k < W; k++) mask_f[k] = (k < int'(n));
  endfunction

  assign din       = s_axis.tdata;
  assign seg_clamp = (seg_size > SEG_W'(MAX_REMOVE_BYTES)) ? SEG_W'(MAX_REMOVE_BYTES) : seg_size;
  // The first beat uses the live seg_size; later beats use the latched copy.
  assign seg_eff   = (state_q == IDLE) ? seg_clamp : seg_q;
  assign slot_free = ~valid_q | m_axis.tready;
  assign s_ready   = slot_free & (state_q != FLUSH) & ~areset;
  assign accept    = s_axis.tvalid & s_ready;

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = dout_q;
  assign m_axis.tkeep  = keep_q;
  assign m_axis.tlast  = last_q;
  assign m_axis.tvalid = valid_q;

  for (genvar j = 0; j < W; j++) begin : g_lane
    segment_remover_lane #(
      .LANE(j), .OFFSET(REMOVE_OFFSET), .CNT_W(CNT_W), .SEG_W(SEG_W)
    ) u_lane (
      .cnt_i (cnt_q),
      .seg_i (seg_eff),
      .vld_i (s_axis.tkeep[j]),
      .keep_o(kept[j])
    );
  end

  // Residue first, then surviving input bytes packed densely; unused bytes stay zero.
  always_comb begin
    comb  = '0;
    total = PW'(rc_q);
    for (int k = 0; k < W; k++)
      if (k < int'(rc_q)) comb[k] = res_q[k];
    for (int j = 0; j < W; j++)
      if (kept[j]) begin
        comb[total] = din[j];
        total       = total + 1'b1;
      end
  end

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rc_d    = rc_q;
    dout_d  = dout_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q & ~m_axis.tready;
    case (state_q)
      FLUSH: begin
        if (slot_free) begin
          dout_d  = res_q;
          keep_d  = mask_f(PW'(rc_q));
          last_d  = 1'b1;
          valid_d = 1'b1;
          res_d   = '0;
          rc_d    = '0;
          state_d = IDLE;
        end
      end
      default: begin
        if (accept) begin
          seg_d = seg_eff;
          if (s_axis.tlast) begin
            cnt_d   = '0;
            valid_d = 1'b1;
            dout_d  = comb[W-1:0];
            if (total <= PW'(W)) begin
              keep_d  = mask_f(total);
              last_d  = 1'b1;
              res_d   = '0;
              rc_d    = '0;
              state_d = IDLE;
            end else begin
              keep_d  = '1;
              last_d  = 1'b0;
              res_d   = comb[2*W-1:W];
              rc_d    = RC_W'(total - PW'(W));
              state_d = FLUSH;
            end
          end else begin
            cnt_d   = cnt_q + CNT_W'(W);
            state_d = BODY;
            if (total >= PW'(W)) begin
              dout_d  = comb[W-1:0];
              keep_d  = '1;
              last_d  = 1'b0;
              valid_d = 1'b1;
              res_d   = comb[2*W-1:W];
              rc_d    = RC_W'(total - PW'(W));
            end else begin
              res_d = comb[W-1:0];
              rc_d  = RC_W'(total);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      seg_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rc_q    <= '0;
      dout_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rc_q    <= rc_d;
      dout_q  <= dout_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

`ifdef SEGMENT_REMOVER_STATS_EN
  logic [PW-1:0]    nrem;
  logic [SEG_W-1:0] rem_acc_q, last_rem_q;
  logic [31:0]      pkt_q, rbytes_q;

  always_comb begin
    nrem = '0;
    for (int j = 0; j < W; j++)
      if (s_axis.tkeep[j] & ~kept[j]) nrem = nrem + 1'b1;
  end

  // Per-packet total is parked until its tlast beat actually leaves.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rem_acc_q  <= '0;
      last_rem_q <= '0;
      pkt_q      <= '0;
      rbytes_q   <= '0;
    end else begin
      if (accept) begin
        if (s_axis.tlast) begin
          rem_acc_q  <= '0;
          last_rem_q <= rem_acc_q + SEG_W'(nrem);
        end else begin
          rem_acc_q  <= rem_acc_q + SEG_W'(nrem);
        end
      end
      if (valid_q & m_axis.tready & last_q) begin
        pkt_q    <= pkt_q + 32'd1;
        rbytes_q <= rbytes_q + 32'(last_rem_q);
      end
    end
  end

  assign stat_pkt_count     = pkt_q;
  assign stat_bytes_removed = rbytes_q;
`endif
endmodule

// File: tb/tb_segment_remover_axis_dyn.sv
// Directed bench for segment_remover_axis_dyn (W=8, REMOVE_OFFSET=12).
module tb_segment_remover_axis_dyn;
  localparam int DW = 64;
  localparam int W  = 8;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic [3:0] seg_size = 4'd0;
  int         n_chk = 0;
  int         n_pass = 0;

  logic [63:0] q_data[$];
  logic [7:0]  q_keep[$];
  logic        q_last[$];

  segment_remover_axis_dyn_if #(.DATA_W(DW)) s_if ();
  segment_remover_axis_dyn_if #(.DATA_W(DW)) m_if ();

`ifdef SEGMENT_REMOVER_STATS_EN
  logic [31:0] stat_pkt_count, stat_bytes_removed;
`endif

  segment_remover_axis_dyn #(
    .AXIS_BUS_WIDTH(64), .MAX_REMOVE_BYTES(8), .REMOVE_OFFSET(12), .MAX_PACKET_LENGTH(1522)
  ) dut (
    .aclk    (aclk),
    .areset  (areset),
    .seg_size(seg_size),
    .s_axis  (s_if),
    .m_axis  (m_if)
`ifdef SEGMENT_REMOVER_STATS_EN
    ,
    .stat_pkt_count    (stat_pkt_count),
    .stat_bytes_removed(stat_bytes_removed)
`endif
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk)
    if (!areset && m_if.tvalid && m_if.tready) begin
      q_data.push_back(m_if.tdata);
      q_keep.push_back(m_if.tkeep);
      q_last.push_back(m_if.tlast);
    end

  function automatic logic [63:0] seq(input int first, input int n, input int lane);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[(lane+k)*8 +: 8] = 8'(first + k);
    return r;
  endfunction

  task automatic clear_q();
    q_data.delete(); q_keep.delete(); q_last.delete();
  endtask

  task automatic send_pkt(input int base, input int len, input int seg0, input int seg1,
                          output int stalls);
    int nb, t;
    stalls = 0;
    for (int b = 0; b * W < len; b++) begin
      nb = len - b * W;
      if (nb > W) nb = W;
      s_if.tdata  = seq(base + b * W, nb, 0);
      s_if.tkeep  = 8'((16'h1 << nb) - 1);
      s_if.tlast  = (b * W + nb == len);
      s_if.tvalid = 1'b1;
      seg_size    = (b == 0) ? 4'(seg0) : 4'(seg1);
      t = 0;
      @(negedge aclk);
      while (!s_if.tready && t < 100) begin
        stalls++; t++;
        @(negedge aclk);
      end
      if (t >= 100) begin
        n_chk++;
        $display("FAIL send_timeout: beat %0d of packet base 0x%0h never accepted", b, base);
      end
      @(posedge aclk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (m_if.tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", m_if.tvalid); else n_pass++;
    n_chk++; if (m_if.tdata !== 64'h0) $display("FAIL rst_tdata: got %h want 0", m_if.tdata); else n_pass++;
    n_chk++; if (m_if.tkeep !== 8'h0) $display("FAIL rst_tkeep: got %h want 0", m_if.tkeep); else n_pass++;
    n_chk++; if (m_if.tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", m_if.tlast); else n_pass++;
    n_chk++; if (s_if.tready !== 1'b0) $display("FAIL rst_tready: got %b want 0", s_if.tready); else n_pass++;
`ifdef SEGMENT_REMOVER_STATS_EN
    n_chk++; if (stat_pkt_count !== 32'd0) $display("FAIL rst_stat_pkt: got %0d want 0", stat_pkt_count); else n_pass++;
`endif
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    n_chk++; if (s_if.tready !== 1'b1) $display("FAIL post_rst_tready: got %b want 1", s_if.tready); else n_pass++;
  endtask

  task automatic test_flush();
    int st, zc;
    logic [63:0] ed[3];
    logic [7:0]  ek[3];
    logic        el[3];
    ed[0] = seq(0, 8, 0);                   ek[0] = 8'hFF; el[0] = 1'b0;
    ed[1] = seq(8, 4, 0) | seq(16, 4, 4);  ek[1] = 8'hFF; el[1] = 1'b0;
    ed[2] = seq(20, 4, 0);                  ek[2] = 8'h0F; el[2] = 1'b1;
    clear_q(); m_if.tready = 1'b1;
    @(posedge aclk); #1;
    send_pkt(0, 24, 4, 4, st);
    zc = 0;
    repeat (4) begin @(negedge aclk); if (!s_if.tready) zc++; end
    n_chk++; if (st + zc !== 1) $display("FAIL flush_tready_low: got %0d cycles want 1", st + zc); else n_pass++;
    n_chk++; if (q_data.size() !== 3) $display("FAIL flush_beats: got %0d want 3", q_data.size()); else n_pass++;
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      n_chk++; if (q_data[i] !== ed[i]) $display("FAIL flush_data[%0d]: got %h want %h", i, q_data[i], ed[i]); else n_pass++;
      n_chk++; if (q_keep[i] !== ek[i]) $display("FAIL flush_keep[%0d]: got %h want %h", i, q_keep[i], ek[i]); else n_pass++;
      n_chk++; if (q_last[i] !== el[i]) $display("FAIL flush_last[%0d]: got %b want %b", i, q_last[i], el[i]); else n_pass++;
    end
  endtask

  task automatic test_short();
    int st;
    logic [63:0] ed[2];
    logic [7:0]  ek[2];
    logic        el[2];
    ed[0] = seq(8'h30, 8, 0); ek[0] = 8'hFF; el[0] = 1'b0;
    ed[1] = seq(8'h38, 2, 0); ek[1] = 8'h03; el[1] = 1'b1;
    clear_q();
    @(posedge aclk); #1;
    send_pkt(8'h30, 10, 4, 4, st);
    repeat (4) @(negedge aclk);
    n_chk++; if (q_data.size() !== 2) $display("FAIL short_beats: got %0d want 2", q_data.size()); else n_pass++;
    for (int i = 0; i < 2 && i < q_data.size(); i++) begin
      n_chk++; if (q_data[i] !== ed[i]) $display("FAIL short_data[%0d]: got %h want %h", i, q_data[i], ed[i]); else n_pass++;
      n_chk++; if (q_keep[i] !== ek[i]) $display("FAIL short_keep[%0d]: got %h want %h", i, q_keep[i], ek[i]); else n_pass++;
      n_chk++; if (q_last[i] !== el[i]) $display("FAIL short_last[%0d]: got %b want %b", i, q_last[i], el[i]); else n_pass++;
    end
  endtask

  task automatic test_trunc();
    int st;
    logic [63:0] ed[2];
    logic [7:0]  ek[2];
    logic        el[2];
`ifdef SEGMENT_REMOVER_STATS_EN
    logic [31:0] p0, r0;
    p0 = stat_pkt_count; r0 = stat_bytes_removed;
`endif
    ed[0] = seq(8'h50, 8, 0); ek[0] = 8'hFF; el[0] = 1'b0;
    ed[1] = seq(8'h58, 4, 0); ek[1] = 8'h0F; el[1] = 1'b1;
    clear_q();
    @(posedge aclk); #1;
    send_pkt(8'h50, 14, 4, 4, st);
    repeat (4) @(negedge aclk);
    n_chk++; if (q_data.size() !== 2) $display("FAIL trunc_beats: got %0d want 2", q_data.size()); else n_pass++;
    for (int i = 0; i < 2 && i < q_data.size(); i++) begin
      n_chk++; if (q_data[i] !== ed[i]) $display("FAIL trunc_data[%0d]: got %h want %h", i, q_data[i], ed[i]); else n_pass++;
      n_chk++; if (q_keep[i] !== ek[i]) $display("FAIL trunc_keep[%0d]: got %h want %h", i, q_keep[i], ek[i]); else n_pass++;
      n_chk++; if (q_last[i] !== el[i]) $display("FAIL trunc_last[%0d]: got %b want %b", i, q_last[i], el[i]); else n_pass++;
    end
`ifdef SEGMENT_REMOVER_STATS_EN
    n_chk++; if (stat_pkt_count - p0 !== 32'd1) $display("FAIL trunc_stat_pkt: got +%0d want +1", stat_pkt_count - p0); else n_pass++;
    n_chk++; if (stat_bytes_removed - r0 !== 32'd2) $display("FAIL trunc_stat_removed: got +%0d want +2", stat_bytes_removed - r0); else n_pass++;
`endif
  endtask

  task automatic test_stall();
    int st;
    logic [73:0] snap;
    logic [63:0] ed[3];
    logic [7:0]  ek[3];
    logic        el[3];
    ed[0] = seq(8'h60, 8, 0);                       ek[0] = 8'hFF; el[0] = 1'b0;
    ed[1] = seq(8'h68, 4, 0) | seq(8'h70, 4, 4);    ek[1] = 8'hFF; el[1] = 1'b0;
    ed[2] = seq(8'h74, 4, 0);                       ek[2] = 8'h0F; el[2] = 1'b1;
    clear_q(); m_if.tready = 1'b1;
    @(posedge aclk); #1;
    fork
      send_pkt(8'h60, 24, 4, 0, st);
      begin
        @(posedge aclk); #1 m_if.tready = 1'b0;
        @(negedge aclk);
        snap = {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata};
        n_chk++; if (snap[73] !== 1'b1) $display("FAIL stall_valid: got %b want 1", snap[73]); else n_pass++;
        for (int c = 0; c < 5; c++) begin
          @(negedge aclk);
          n_chk++;
          if ({m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata} !== snap)
            $display("FAIL stall_stable[%0d]: got %h want %h", c, {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata}, snap);
          else n_pass++;
          n_chk++; if (s_if.tready !== 1'b0) $display("FAIL stall_tready[%0d]: got %b want 0", c, s_if.tready); else n_pass++;
        end
        @(posedge aclk); #1 m_if.tready = 1'b1;
      end
    join
    repeat (5) @(negedge aclk);
    n_chk++; if (q_data.size() !== 3) $display("FAIL stall_beats: got %0d want 3", q_data.size()); else n_pass++;
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      n_chk++; if (q_data[i] !== ed[i]) $display("FAIL stall_data[%0d]: got %h want %h", i, q_data[i], ed[i]); else n_pass++;
      n_chk++; if (q_keep[i] !== ek[i]) $display("FAIL stall_keep[%0d]: got %h want %h", i, q_keep[i], ek[i]); else n_pass++;
      n_chk++; if (q_last[i] !== el[i]) $display("FAIL stall_last[%0d]: got %b want %b", i, q_last[i], el[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int st0, st1;
    logic [63:0] ed[4];
    logic [7:0]  ek[4];
    logic        el[4];
    ed[0] = seq(8'h80, 8, 0); ek[0] = 8'hFF; el[0] = 1'b0;
    ed[1] = seq(8'h88, 8, 0); ek[1] = 8'hFF; el[1] = 1'b1;
    ed[2] = seq(8'hC0, 8, 0); ek[2] = 8'hFF; el[2] = 1'b0;
    ed[3] = seq(8'hC8, 4, 0); ek[3] = 8'h0F; el[3] = 1'b1;
    clear_q(); m_if.tready = 1'b1;
    @(posedge aclk); #1;
    send_pkt(8'h80, 16, 0, 0, st0);
    send_pkt(8'hC0, 16, 8, 8, st1);
    repeat (4) @(negedge aclk);
    n_chk++; if (st0 + st1 !== 0) $display("FAIL b2b_bubbles: got %0d want 0", st0 + st1); else n_pass++;
    n_chk++; if (q_data.size() !== 4) $display("FAIL b2b_beats: got %0d want 4", q_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_chk++; if (q_data[i] !== ed[i]) $display("FAIL b2b_data[%0d]: got %h want %h", i, q_data[i], ed[i]); else n_pass++;
      n_chk++; if (q_keep[i] !== ek[i]) $display("FAIL b2b_keep[%0d]: got %h want %h", i, q_keep[i], ek[i]); else n_pass++;
      n_chk++; if (q_last[i] !== el[i]) $display("FAIL b2b_last[%0d]: got %b want %b", i, q_last[i], el[i]); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    int st;
    m_if.tready = 1'b1;
    @(posedge aclk); #1;
    seg_size = 4'd4; s_if.tvalid = 1'b1; s_if.tlast = 1'b0; s_if.tkeep = 8'hFF;
    for (int b = 0; b < 3; b++) begin
      s_if.tdata = seq(8'h10 + 8 * b, 8, 0);
      @(posedge aclk); #1;
    end
    s_if.tvalid = 1'b0; m_if.tready = 1'b0;
    #1;
    n_chk++; if (m_if.tvalid !== 1'b1) $display("FAIL arst_pre_valid: got %b want 1", m_if.tvalid); else n_pass++;
    #1 areset = 1'b1;
    #1;
    n_chk++; if (m_if.tvalid !== 1'b0) $display("FAIL arst_tvalid: got %b want 0", m_if.tvalid); else n_pass++;
    n_chk++; if (m_if.tdata !== 64'h0) $display("FAIL arst_tdata: got %h want 0", m_if.tdata); else n_pass++;
    n_chk++; if (m_if.tkeep !== 8'h0) $display("FAIL arst_tkeep: got %h want 0", m_if.tkeep); else n_pass++;
    n_chk++; if (s_if.tready !== 1'b0) $display("FAIL arst_tready: got %b want 0", s_if.tready); else n_pass++;
    @(posedge aclk); #1 areset = 1'b0; m_if.tready = 1'b1;
    clear_q();
    send_pkt(8'hA0, 8, 4, 4, st);
    repeat (4) @(negedge aclk);
    n_chk++; if (q_data.size() !== 1) $display("FAIL arst_beats: got %0d want 1", q_data.size()); else n_pass++;
    if (q_data.size() > 0) begin
      n_chk++; if (q_data[0] !== seq(8'hA0, 8, 0)) $display("FAIL arst_data: got %h want %h", q_data[0], seq(8'hA0, 8, 0)); else n_pass++;
      n_chk++; if (q_keep[0] !== 8'hFF) $display("FAIL arst_keep: got %h want ff", q_keep[0]); else n_pass++;
      n_chk++; if (q_last[0] !== 1'b1) $display("FAIL arst_last: got %b want 1", q_last[0]); else n_pass++;
    end
  endtask

  initial begin
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    test_reset();
    test_flush();
    test_short();
    test_trunc();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
